// File: rtl/otter_crypto_pkg.sv
// Shared definitions for the OTTER ENCRY round sequencer: the sequencer
// state type, the ENCRY opcode, the func3 direction encodings and the
// default round count.
package otter_crypto_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ROUND  = 2'd2,
        ST_FINISH = 2'd3
    } crypto_state_t;

    localparam logic [6:0] ENCRY_OPCODE  = 7'b1011011;
    localparam logic [2:0] CRYPTO_F3_ENC = 3'b000;
    localparam logic [2:0] CRYPTO_F3_DEC = 3'b001;

    localparam int CRYPTO_NUM_ROUNDS_DEFAULT = 4;

    // Only the two direction encodings are legal ENCRY func3 values.
    function automatic logic crypto_f3_legal(input logic [2:0] f3);
        return (f3 == CRYPTO_F3_ENC) || (f3 == CRYPTO_F3_DEC);
    endfunction

endpackage

// File: rtl/otter_crypto_seq.sv
// Round sequencer for the ENCRY instruction. Turns a level START from the
// control unit into the load / round / latch strobe sequence of the crypto
// datapath and answers with a BUSY level and a one-cycle DONE pulse.
// Encrypt walks the round-key index upward, decrypt walks it downward.
module otter_crypto_seq
    import otter_crypto_pkg::*;
#(
    parameter int NUM_ROUNDS = CRYPTO_NUM_ROUNDS_DEFAULT,
    parameter int RND_W      = $clog2(NUM_ROUNDS)
) (
    input  logic             CRYPTO_CLK,
    input  logic             CRYPTO_RESET,
    input  logic             CRYPTO_START,
    input  logic [2:0]       CRYPTO_FUNC3,
    input  logic             CRYPTO_ABORT,
    output logic             CRYPTO_BUSY,
    output logic             CRYPTO_DONE,
    output logic             CRYPTO_ERR,
    output logic             DP_LOAD,
    output logic             DP_ROUND_EN,
    output logic [RND_W-1:0] DP_ROUND_IDX,
    output logic             DP_DECRYPT,
    output logic             DP_OUT_LATCH
);

    localparam logic [RND_W-1:0] LAST_IDX = RND_W'(NUM_ROUNDS - 1);
    localparam logic [RND_W-1:0] IDX_ONE  = RND_W'(1);

    crypto_state_t    state;
    logic [RND_W-1:0] round_cnt;
    logic             mode_dec;   // latched direction, only nonzero while busy
    logic             err_q;
    logic             busy_q;
    logic             load_q;
    logic             round_en_q;
    logic             finish_q;   // drives both DONE and OUT_LATCH

    // Terminal round for the current direction; the FSM leaves ROUND here,
    // so the counter never steps past either end of its range.
    logic last_round;
    assign last_round = mode_dec ? (round_cnt == '0) : (round_cnt == LAST_IDX);

    // Sequencer FSM: every strobe is registered together with the state it
    // belongs to, so outputs change only on clock edges (or reset).
    // NOTE: all state and output registers use non-blocking assignments so
    // every branch reads the pre-edge values, whatever the statement order.
    always_ff @(posedge CRYPTO_CLK or posedge CRYPTO_RESET) begin
        if (CRYPTO_RESET) begin
            state      <= ST_IDLE;
            round_cnt  <= '0;
            mode_dec   <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            load_q     <= 1'b0;
            round_en_q <= 1'b0;
            finish_q   <= 1'b0;
        end else if (CRYPTO_ABORT) begin
            // Abort drops straight to IDLE: no DONE, no result latch, and a
            // START/ERR in the same cycle is discarded.
            state      <= ST_IDLE;
            round_cnt  <= '0;
            mode_dec   <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            load_q     <= 1'b0;
            round_en_q <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            // ERR is a single-cycle pulse unless IDLE re-arms it below.
            err_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (CRYPTO_START) begin
                        if (crypto_f3_legal(CRYPTO_FUNC3)) begin
                            state    <= ST_LOAD;
                            busy_q   <= 1'b1;
                            load_q   <= 1'b1;
                            mode_dec <= CRYPTO_FUNC3[0];
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    state      <= ST_ROUND;
                    load_q     <= 1'b0;
                    round_en_q <= 1'b1;
                    round_cnt  <= mode_dec ? LAST_IDX : '0;
                end

                ST_ROUND: begin
                    if (last_round) begin
                        state      <= ST_FINISH;
                        round_en_q <= 1'b0;
                        finish_q   <= 1'b1;
                    end else if (mode_dec) begin
                        round_cnt <= round_cnt - IDX_ONE;
                    end else begin
                        round_cnt <= round_cnt + IDX_ONE;
                    end
                end

                ST_FINISH: begin
                    state     <= ST_IDLE;
                    busy_q    <= 1'b0;
                    finish_q  <= 1'b0;
                    mode_dec  <= 1'b0;
                    round_cnt <= '0;
                end

                default: begin
                    state      <= ST_IDLE;
                    busy_q     <= 1'b0;
                    load_q     <= 1'b0;
                    round_en_q <= 1'b0;
                    finish_q   <= 1'b0;
                    mode_dec   <= 1'b0;
                    round_cnt  <= '0;
                end
            endcase
        end
    end

    assign CRYPTO_BUSY  = busy_q;
    assign CRYPTO_DONE  = finish_q;
    assign CRYPTO_ERR   = err_q;
    assign DP_LOAD      = load_q;
    assign DP_ROUND_EN  = round_en_q;
    assign DP_ROUND_IDX = round_cnt;
    assign DP_DECRYPT   = mode_dec;
    assign DP_OUT_LATCH = finish_q;

endmodule
